// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M/RV64M multiply/divide engine for the execute stage.
// Operands are converted to magnitudes on accept. Multiplies use an iterative
// shift-add that retires MUL_BPC multiplier bits per cycle. Divides use a restoring
// divider that produces one quotient bit per cycle. FIX restores the result signs
// and registers the response. A one-entry cache of the last iterated result lets
// the paired op (MUL/MULH*, DIV/REM) on the same operands complete in one cycle.
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   flush_i              kills the in-flight op and any pending response
//   req_valid_i/ready_o  request handshake; func3, rs1, rs2 and tag travel with it
//   rsp_valid_o/ready_i  response handshake; data and tag stay stable until taken
//   busy_o               high whenever the engine is not idle
module muldiv_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BPC  = 2,
    parameter int unsigned TAG_W    = 5,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_func3_i,
    input  logic [XLEN-1:0]  req_rs1_i,
    input  logic [XLEN-1:0]  req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [XLEN-1:0]  rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);
    localparam int unsigned PW    = 2 * XLEN;
    localparam int unsigned SW    = XLEN + MUL_BPC;
    localparam int unsigned MUL_K = XLEN / MUL_BPC;
    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    typedef enum logic [2:0] {C_MULS, C_MULSU, C_MULU, C_DIVS, C_DIVU} cls_t;

    state_t            state;
    logic [PW-1:0]     acc;       // mul: {partial hi, multiplier}; div: {rem, quot}
    logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [CNT_W-1:0]  cnt;
    logic              neg_lo_q;  // negate product / quotient
    logic              neg_hi_q;  // negate remainder
    logic              is_div_q;
    logic              sel_hi_q;  // return upper word (MULH*, REM*)
    logic              iter_q;    // op iterated, so its result goes to the cache
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    cls_t              cls_q;

    logic              c_valid;
    logic [XLEN-1:0]   c_rs1;
    logic [XLEN-1:0]   c_rs2;
    cls_t              c_cls;
    logic [PW-1:0]     c_data;

    logic              accept;
    logic              req_div;
    logic              req_sel_hi;
    logic              a_signed;
    logic              b_signed;
    logic              req_sa;
    logic              req_sb;
    logic [XLEN-1:0]   req_mag_a;
    logic [XLEN-1:0]   req_mag_b;
    logic              req_b_zero;
    logic              req_ovf;
    cls_t              req_cls;
    logic              cache_hit;

    logic [SW-1:0]     mul_sum;
    logic [PW-1:0]     mul_next;
    logic [XLEN:0]     div_shift;
    logic [PW-1:0]     div_next;
    logic [PW-1:0]     fix_val;
    logic [XLEN-1:0]   fix_res;
    logic [XLEN-1:0]   hit_res;

    assign req_ready_o = !flush_i && (state == S_IDLE || (state == S_DONE && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign busy_o      = (state != S_IDLE);

    // Request decode: signedness, magnitudes, special cases, cache lookup
    always_comb begin
        a_signed   = 1'b0;
        b_signed   = 1'b0;
        req_cls    = C_MULU;
        req_div    = req_func3_i[2];
        req_sel_hi = req_div ? req_func3_i[1] : (req_func3_i[1:0] != 2'b00);
        case (req_func3_i)
            3'b001: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
                req_cls  = C_MULS;
            end
            3'b010: begin
                a_signed = 1'b1;
                req_cls  = C_MULSU;
            end
            3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
                req_cls  = C_DIVS;
            end
            3'b101, 3'b111: req_cls = C_DIVU;
            default: req_cls = C_MULU;  // MUL: low word is sign-independent
        endcase
        req_sa     = a_signed && req_rs1_i[XLEN-1];
        req_sb     = b_signed && req_rs2_i[XLEN-1];
        req_mag_a  = req_sa ? -req_rs1_i : req_rs1_i;
        req_mag_b  = req_sb ? -req_rs2_i : req_rs2_i;
        req_b_zero = (req_rs2_i == '0);
        req_ovf    = req_div && b_signed && (req_rs1_i == MIN_VAL) && (&req_rs2_i);
        // MUL accepts any stored product: all mul classes agree on the low word
        cache_hit  = CACHE_EN && c_valid && (req_rs1_i == c_rs1) && (req_rs2_i == c_rs2) &&
                     ((req_cls == c_cls) ||
                      (req_func3_i == 3'b000 &&
                       (c_cls == C_MULS || c_cls == C_MULSU || c_cls == C_MULU)));
    end

    // Iteration steps and sign fix-up
    always_comb begin
        mul_sum   = SW'(acc[PW-1:XLEN]) + SW'(opnd) * SW'(acc[MUL_BPC-1:0]);
        mul_next  = PW'({mul_sum, acc[XLEN-1:0]} >> MUL_BPC);
        div_shift = acc[PW-1:XLEN-1];
        if (div_shift >= {1'b0, opnd}) begin
            div_next = {XLEN'(div_shift - {1'b0, opnd}), acc[XLEN-2:0], 1'b1};
        end else begin
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
        if (is_div_q) begin
            fix_val = {(neg_hi_q ? -acc[PW-1:XLEN] : acc[PW-1:XLEN]),
                       (neg_lo_q ? -acc[XLEN-1:0] : acc[XLEN-1:0])};
        end else begin
            fix_val = neg_lo_q ? -acc : acc;
        end
        fix_res = sel_hi_q ? fix_val[PW-1:XLEN] : fix_val[XLEN-1:0];
        hit_res = req_sel_hi ? c_data[PW-1:XLEN] : c_data[XLEN-1:0];
    end

    // Control FSM, datapath registers and result cache
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            acc         <= '0;
            opnd        <= '0;
            cnt         <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            is_div_q    <= 1'b0;
            sel_hi_q    <= 1'b0;
            iter_q      <= 1'b0;
            tag_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            cls_q       <= C_MULS;
            c_valid     <= 1'b0;
            c_rs1       <= '0;
            c_rs2       <= '0;
            c_cls       <= C_MULS;
            c_data      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_tag_o   <= '0;
        end else if (flush_i) begin
            state       <= S_IDLE;
            rsp_valid_o <= 1'b0;
        end else begin
            case (state)
                S_MUL: begin
                    acc <= mul_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    rsp_data_o  <= fix_res;
                    rsp_tag_o   <= tag_q;
                    rsp_valid_o <= 1'b1;
                    state       <= S_DONE;
                    if (CACHE_EN && iter_q) begin
                        c_valid <= 1'b1;
                        c_rs1   <= rs1_q;
                        c_rs2   <= rs2_q;
                        c_cls   <= cls_q;
                        c_data  <= fix_val;
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // A new request overrides the DONE->IDLE step, giving bubble-free issue
            if (accept) begin
                tag_q    <= req_tag_i;
                sel_hi_q <= req_sel_hi;
                is_div_q <= req_div;
                rs1_q    <= req_rs1_i;
                rs2_q    <= req_rs2_i;
                cls_q    <= req_cls;
                neg_lo_q <= req_sa ^ req_sb;
                neg_hi_q <= req_sa;
                iter_q   <= 1'b1;
                if (cache_hit) begin
                    rsp_data_o  <= hit_res;
                    rsp_tag_o   <= req_tag_i;
                    rsp_valid_o <= 1'b1;
                    state       <= S_DONE;
                end else if (req_div && req_b_zero) begin
                    acc      <= {req_rs1_i, {XLEN{1'b1}}};
                    neg_lo_q <= 1'b0;
                    neg_hi_q <= 1'b0;
                    iter_q   <= 1'b0;
                    state    <= S_FIX;
                end else if (req_ovf) begin
                    acc      <= {{XLEN{1'b0}}, MIN_VAL};
                    neg_lo_q <= 1'b0;
                    neg_hi_q <= 1'b0;
                    iter_q   <= 1'b0;
                    state    <= S_FIX;
                end else if (req_div) begin
                    acc   <= {{XLEN{1'b0}}, req_mag_a};
                    opnd  <= req_mag_b;
                    cnt   <= CNT_W'(XLEN - 1);
                    state <= S_DIV;
                end else begin
                    acc   <= {{XLEN{1'b0}}, req_mag_b};
                    opnd  <= req_mag_a;
                    cnt   <= CNT_W'(MUL_K - 1);
                    state <= S_MUL;
                end
            end
        end
    end
endmodule
